// File: rtl/serial_add_pkg.sv
// Shared types and width limits for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit full adder: the one arithmetic cell the serial controller reuses every clock.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH bits, LSB first, with valid/ready on both sides.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that turns the operation into a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range 2..32");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   b_load;
  logic               cin_load;
  logic               cell_s, cell_c;
  logic               last_bit;

  // Subtraction is a + ~b + 1, so only the loaded B value and initial carry change.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ? 1'b1 : cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  fa_bit_cell u_cell (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (cell_s),
    .carry (cell_c)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d     = a;
          b_sh_d     = b_load;
          carry_d    = cin_load;
          cnt_d      = '0;
          sum_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        carry_d = cell_c;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // carry_q is the carry into the MSB; cell_c is the carry out of it.
          cout_d      = cell_c;
          ovf_d       = carry_q ^ cell_c;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Operand shifters are pure datapath; they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected results, a negedge monitor pops and compares.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   rand_ready = 1'b0;
  bit   b2b_mode   = 1'b0;
  int   last_acc   = -1;
  logic prev_ov    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word arithmetic, then signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic do_sub);
    exp_t         m;
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         cc;
    yy     = do_sub ? ~y : y;
    cc     = do_sub ? 1'b1 : ci;
    full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    m.s    = full[W-1:0];
    m.co   = full[W];
    m.ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    m.acc  = 0;
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
        else                check("latency", 32'(cyc - sb[0].acc), 32'(W));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_handshake", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sum",  32'(sum),  32'(mon_e.s));
          check("cout", 32'(cout), 32'(mon_e.co));
          check("ovf",  32'(ovf),  32'(mon_e.ov));
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called and returns at posedge+1; waits (bounded) for acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      input logic do_sub, input bit keep);
    exp_t e;
    int   n = 0;
    bit   done = 1'b0;
    in_valid = 1'b1;
    a   = x;
    b   = y;
    cin = ci;
`ifdef SERIAL_ADD_SUB_EN
    sub = do_sub;
`endif
    while (!done && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(x, y, ci, do_sub);
        e.acc = cyc + 1;
        if (b2b_mode && last_acc >= 0) check("issue_interval", 32'(e.acc - last_acc), 32'(W + 2));
        last_acc = e.acc;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    if (!keep) begin
      in_valid = 1'b0;
      a = 'x;
      b = 'x;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_sum"},       32'(sum),       32'd0);
    check({tag, "_cout"},      32'(cout),      32'd0);
    check({tag, "_ovf"},       32'(ovf),       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s0;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    drain();
    send(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b0);
    drain();

    // Stalled consumer: result must hold still and no new operand may be taken.
    out_ready = 1'b0;
    send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("stall_reach_done", 32'(out_valid), 32'd1);
    s0 = sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_sum",      32'(sum),       32'(s0));
      check("stall_in_ready", 32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("hs_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("post_hs_in_ready",  32'(in_ready),  32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    drain();

    // Back-to-back with in_valid held high throughout.
    b2b_mode = 1'b1;
    last_acc = -1;
    send(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    send(8'hC3, 8'h9E, 1'b1, 1'b0, 1'b1);
    send(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    drain();
    b2b_mode = 1'b0;

    // Reset while processing bit 3.
    send(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check_idle_reset("abort");
    repeat (12) @(posedge clk);
    #1;
    send(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef SERIAL_ADD_SUB_EN
    send(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    drain();
    send(8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic ds;
      ds = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ds = 1'($urandom_range(0, 1));
`endif
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ds, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rand_ready = 1'b0;
    #1;
    out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
